wallace_final_adder: RTL
========================

// Module: wallace_final_adder
//
// PURPOSE
//   Final carry-propagate stage of the Booth/Wallace multiplier. It takes the
//   redundant sum and carry vectors left by the FullAdder compressor tree and
//   resolves them into a binary product. The ripple add runs CHUNK bits per
//   cycle, so the carry chain per cycle is bounded by CHUNK full-adder delays.
//   Valid/ready handshakes sit on both sides: the tree upstream, the product
//   consumer downstream.
//
// PARAMETERS
//   WIDTH  32  width of Sum_Vec, Carry_Vec and Product
//   CHUNK  8   bits resolved per cycle; WIDTH % CHUNK must be 0, else elaboration error
//
// PORTS
//   Clk        in   1      rising-edge clock
//   Rst_n      in   1      asynchronous, active-low reset
//   In_Valid   in   1      Sum_Vec/Carry_Vec valid
//   In_Ready   out  1      block can accept; equals (state==IDLE)
//   Sum_Vec    in   WIDTH  tree sum vector; bit i has weight 2^i
//   Carry_Vec  in   WIDTH  tree carry vector, already aligned; bit i has weight 2^i
//   Out_Valid  out  1      Product/Overflow valid
//   Out_Ready  in   1      consumer accepts Product
//   Product    out  WIDTH  (Sum_Vec + Carry_Vec) mod 2^WIDTH
//   Overflow   out  1      carry out of bit WIDTH-1
//
// BEHAVIOUR
//   - N = WIDTH/CHUNK. Chunk counter width = max(1, clog2(N)).
//   - Reset (Rst_n=0, async): state=IDLE, Out_Valid=0, Product=0, Overflow=0,
//     chunk idx=0, carry=0. In_Ready=1, because it is decoded from IDLE.
//   - IDLE: on In_Valid & In_Ready, capture Sum_Vec/Carry_Vec, set carry=0 and
//     idx=0, go to ADD. In_Valid without a handshake has no effect.
//   - ADD: each cycle {carry, Product[idx*CHUNK +: CHUNK]} =
//     S[chunk] + C[chunk] + carry; then idx++. After chunk N-1: Overflow=carry,
//     Out_Valid=1, go to DONE. Product bits above the current chunk are don't-care in ADD.
//   - Latency: Out_Valid rises N clock edges after the accepting edge
//     (4 for defaults). CHUNK==WIDTH gives latency 1.
//   - DONE: Product, Overflow and Out_Valid hold stable until Out_Valid & Out_Ready.
//     On that edge: Out_Valid=0, go to IDLE. In_Ready=1 the following cycle.
//     Product keeps its last value.
//   - In_Ready=0 in ADD and DONE. No accept in the same cycle as output
//     handoff. Throughput: one op per N+2 cycles minimum.
//   - Captured operands are private copies. Input changes after accept are ignored.
//   - Rst_n asserted mid-ADD or in DONE aborts the operation: all outputs go to
//     reset values immediately, and the result is discarded.
//   - Unsigned modular add. Signed interpretation is the consumer's concern.
//
// CONFIGURATION
//   CPA_ZERO_FLAG_EN defined: adds output port Zero (1 bit). Zero is
//     registered and updates on the same edge as Overflow/Out_Valid:
//     1 iff the final Product == 0. It holds through DONE, and its reset value is 0.
//   Not defined: no Zero port, no zero-detect logic. Everything else is identical.
//
// TESTING (WIDTH=32, CHUNK=8)
//   1 Sum=0x0000FFFF, Carry=0x00000001 -> Product=0x00010000, Overflow=0;
//     Out_Valid exactly 4 edges after accept.
//   2 Sum=0x12345678, Carry=0x0FEDCBA8 -> Product=0x22222220, Overflow=0
//     (carry crosses every chunk boundary).
//   3 Sum=0xFFFFFFFF, Carry=0x00000001 -> Product=0x00000000, Overflow=1;
//     Zero=1 with CPA_ZERO_FLAG_EN.
//   4 Hold Out_Ready=0 for 10 cycles in DONE while toggling In_Valid and
//     operands -> Product/Out_Valid stable, In_Ready=0, no new capture.
//   5 Drop Rst_n for 1 cycle at ADD idx=2 -> Out_Valid=0, Product=0,
//     In_Ready=1. Next op returns the correct result.
//   6 1000 random operand pairs with random In_Valid/Out_Ready gaps ->
//     every Product and Overflow matches a 33-bit reference add. No drops, no duplicates.

Source files
------------

// File: rtl/wallace_final_adder_if.sv
// Handshake bus for the multiplier's final carry-propagate adder.
// Upstream side: In_Valid/In_Ready with Sum_Vec/Carry_Vec operands.
// Downstream side: Out_Valid/Out_Ready with Product/Overflow results.
// The Zero flag and its modport entries exist only when CPA_ZERO_FLAG_EN is defined.
interface wallace_final_adder_if #(
  parameter int WIDTH = 32
);
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Sum_Vec;
  logic [WIDTH-1:0] Carry_Vec;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Product;
  logic             Overflow;
`ifdef CPA_ZERO_FLAG_EN
  logic             Zero;

  // Master drives the operands and consumes the product.
  modport master (
    output In_Valid, Sum_Vec, Carry_Vec, Out_Ready,
    input  In_Ready, Out_Valid, Product, Overflow, Zero
  );

  // Slave is the adder itself.
  modport slave (
    input  In_Valid, Sum_Vec, Carry_Vec, Out_Ready,
    output In_Ready, Out_Valid, Product, Overflow, Zero
  );
`else
  // Master drives the operands and consumes the product.
  modport master (
    output In_Valid, Sum_Vec, Carry_Vec, Out_Ready,
    input  In_Ready, Out_Valid, Product, Overflow
  );

  // Slave is the adder itself.
  modport slave (
    input  In_Valid, Sum_Vec, Carry_Vec, Out_Ready,
    output In_Ready, Out_Valid, Product, Overflow
  );
`endif
endinterface

// File: rtl/wallace_final_adder.sv
// Final carry-propagate stage of the Booth/Wallace multiplier.
// The redundant sum/carry pair is resolved CHUNK bits per clock, which bounds
// the per-cycle carry chain to CHUNK full adders.
// The operation takes WIDTH/CHUNK add cycles. The result then holds until the
// consumer takes it.
// Optional feature: define CPA_ZERO_FLAG_EN to add a registered Zero flag.
module wallace_final_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  wallace_final_adder_if.slave  bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Refuse to build a configuration that would leave a partial chunk.
  if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("wallace_final_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   cvec_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cy_q;
  logic [WIDTH-1:0]   product_q;
  logic               overflow_q;
  logic               out_valid_q;

  logic [CHUNK:0]     chunk_d;
  logic [WIDTH-1:0]   product_d;
  int                 base;

  // One chunk of ripple add: slice both operands at idx, add in the carry.
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    chunk_d   = {1'b0, sum_q[base +: CHUNK]} + {1'b0, cvec_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q};
    product_d = product_q;
    product_d[base +: CHUNK] = chunk_d[CHUNK-1:0];
  end

`ifdef CPA_ZERO_FLAG_EN
  logic zero_q;

  // Zero is evaluated on the full product vector in the last add cycle.
  // By then every lower chunk has been written.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      zero_q <= 1'b0;
    end else if (state_q == ADD && idx_q == LAST_IDX) begin
      zero_q <= (product_d == '0);
    end
  end

  assign bus.Zero = zero_q;
`endif

  // Control FSM and datapath registers. The operands are captured privately,
  // so upstream may change them freely once the accept has happened.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cvec_q      <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.In_Valid) begin
            sum_q   <= bus.Sum_Vec;
            cvec_q  <= bus.Carry_Vec;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD: begin
          product_q <= product_d;
          cy_q      <= chunk_d[CHUNK];
          if (idx_q == LAST_IDX) begin
            overflow_q  <= chunk_d[CHUNK];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.Out_Ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.In_Ready  = (state_q == IDLE);
  assign bus.Out_Valid = out_valid_q;
  assign bus.Product   = product_q;
  assign bus.Overflow  = overflow_q;
endmodule
